// File: rtl/mmap_axi_responder_pkg.sv
// -----------------------------------------------------------------------------
// mmap_axi_responder_pkg
// Shared AXI constants, the read/write FSM state encodings, and the rule that
// flags a burst as unsupported (wrong beat size or non-INCR burst type).
// No ports: imported by mmap_beat_addr_gen and mmap_axi_responder.
// -----------------------------------------------------------------------------
package mmap_axi_responder_pkg;

  localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;

  typedef enum logic {
    R_IDLE,
    R_BURST
  } rd_state_e;

  typedef enum logic [1:0] {
    W_IDLE,
    W_DATA,
    W_RESP
  } wr_state_e;

  // A burst is serviced regardless, but answered with SLVERR when the beat
  // size is not the full bus width or the burst is not INCR.
  function automatic logic burst_err(input logic [2:0] size,
                                     input logic [1:0] burst,
                                     input int unsigned bytes_log);
    return (size != 3'(bytes_log)) || (burst != AXI_BURST_INCR);
  endfunction

endpackage

// File: rtl/mmap_beat_addr_gen.sv
// -----------------------------------------------------------------------------
// mmap_beat_addr_gen
// Latches a burst's base address and length, then counts beats. Provides the
// address of the current beat (base + beat * bus width, wrapping at
// 2^AddrWidth), an is_last flag and an in_range flag (beat <= len).
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   load            capture base/len and clear the beat counter
//   base, len       burst base address and AXI length (beats - 1)
//   step            advance to the next beat
//   beat            9-bit beat counter (len = 255 needs 256 counts + done)
//   addr            address of the current beat
//   is_last         beat == len
//   in_range        beat <= len
// -----------------------------------------------------------------------------
module mmap_beat_addr_gen
  import mmap_axi_responder_pkg::*;
#(
  parameter int AddrWidth         = 64,
  parameter int DataWidthBytesLog = 6
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 load,
  input  logic [AddrWidth-1:0] base,
  input  logic [7:0]           len,
  input  logic                 step,
  output logic [8:0]           beat,
  output logic [AddrWidth-1:0] addr,
  output logic                 is_last,
  output logic                 in_range
);

  logic [AddrWidth-1:0] base_q;
  logic [7:0]           len_q;
  logic [8:0]           beat_q;

  // NOTE: sequential state is written with non-blocking assignments so every
  // flop samples pre-edge values, independent of block evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      base_q <= '0;
      len_q  <= '0;
      beat_q <= '0;
    end else if (load) begin
      base_q <= base;
      len_q  <= len;
      beat_q <= '0;
    end else if (step) begin
      beat_q <= beat_q + 9'd1;
    end
  end

  assign beat     = beat_q;
  assign addr     = base_q + (AddrWidth'(beat_q) << DataWidthBytesLog);
  assign is_last  = (beat_q == {1'b0, len_q});
  assign in_range = (beat_q <= {1'b0, len_q});

endmodule

// File: rtl/mmap_axi_responder.sv
// -----------------------------------------------------------------------------
// mmap_axi_responder
// AXI4 slave that unrolls AR/AW bursts into per-beat address streams on
// FIFO-style user ports and closes each burst from the returned read data or
// the forwarded write beats. Read and write paths are fully independent; one
// burst is outstanding per direction.
// Ports:
//   clk, rst_n                       clock, asynchronous active-low reset
//   s_axi_AR*/R*                     AXI read address / read data channels
//   s_axi_AW*/W*/B*                  AXI write address / data / response
//   read_addr_{din,write,full_n}     per-beat read address to the user
//   read_data_{dout,empty_n,read}    per-beat read data from the user (in order)
//   write_addr_{din,write,full_n}    per-beat write address to the user
//   write_data_{din,write,full_n}    per-beat write data to the user
// -----------------------------------------------------------------------------
module mmap_axi_responder
  import mmap_axi_responder_pkg::*;
#(
  parameter int AddrWidth         = 64,
  parameter int DataWidth         = 512,
  parameter int DataWidthBytesLog = 6,
  parameter int IdWidth           = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  // read address channel
  input  logic                   s_axi_ARVALID,
  output logic                   s_axi_ARREADY,
  input  logic [AddrWidth-1:0]   s_axi_ARADDR,
  input  logic [IdWidth-1:0]     s_axi_ARID,
  input  logic [7:0]             s_axi_ARLEN,
  input  logic [2:0]             s_axi_ARSIZE,
  input  logic [1:0]             s_axi_ARBURST,
  // read data channel
  output logic                   s_axi_RVALID,
  input  logic                   s_axi_RREADY,
  output logic [DataWidth-1:0]   s_axi_RDATA,
  output logic [IdWidth-1:0]     s_axi_RID,
  output logic [1:0]             s_axi_RRESP,
  output logic                   s_axi_RLAST,
  // write address channel
  input  logic                   s_axi_AWVALID,
  output logic                   s_axi_AWREADY,
  input  logic [AddrWidth-1:0]   s_axi_AWADDR,
  input  logic [IdWidth-1:0]     s_axi_AWID,
  input  logic [7:0]             s_axi_AWLEN,
  input  logic [2:0]             s_axi_AWSIZE,
  input  logic [1:0]             s_axi_AWBURST,
  // write data channel
  input  logic                   s_axi_WVALID,
  output logic                   s_axi_WREADY,
  input  logic [DataWidth-1:0]   s_axi_WDATA,
  input  logic [DataWidth/8-1:0] s_axi_WSTRB,
  input  logic                   s_axi_WLAST,
  // write response channel
  output logic                   s_axi_BVALID,
  input  logic                   s_axi_BREADY,
  output logic [IdWidth-1:0]     s_axi_BID,
  output logic [1:0]             s_axi_BRESP,
  // user side
  output logic [AddrWidth-1:0]   read_addr_din,
  output logic                   read_addr_write,
  input  logic                   read_addr_full_n,
  input  logic [DataWidth-1:0]   read_data_dout,
  input  logic                   read_data_empty_n,
  output logic                   read_data_read,
  output logic [AddrWidth-1:0]   write_addr_din,
  output logic                   write_addr_write,
  input  logic                   write_addr_full_n,
  output logic [DataWidth-1:0]   write_data_din,
  output logic                   write_data_write,
  input  logic                   write_data_full_n
);

  // Holds both address READYs low for the first cycle after reset release.
  logic init_done;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) init_done <= 1'b0;
    else        init_done <= 1'b1;
  end

  // ---------------------------------------------------------------------------
  // Read path
  // ---------------------------------------------------------------------------
  rd_state_e            rd_state;
  logic                 rd_err;
  logic [IdWidth-1:0]   rd_id;
  logic                 ar_hs;
  logic                 r_hs;
  logic [AddrWidth-1:0] iss_addr;
  logic                 iss_in_range;
  logic                 ret_is_last;

  assign s_axi_ARREADY   = init_done && (rd_state == R_IDLE);
  assign ar_hs           = s_axi_ARVALID && s_axi_ARREADY;

  assign read_addr_write = (rd_state == R_BURST) && read_addr_full_n && iss_in_range;
  assign read_addr_din   = iss_addr;

  assign s_axi_RVALID    = (rd_state == R_BURST) && read_data_empty_n;
  assign r_hs            = s_axi_RVALID && s_axi_RREADY;
  assign read_data_read  = r_hs;
  assign s_axi_RDATA     = read_data_dout;
  assign s_axi_RID       = rd_id;
  assign s_axi_RRESP     = rd_err ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
  assign s_axi_RLAST     = ret_is_last;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_state <= R_IDLE;
      rd_err   <= 1'b0;
      rd_id    <= '0;
    end else begin
      case (rd_state)
        R_IDLE: if (ar_hs) begin
          rd_state <= R_BURST;
          rd_id    <= s_axi_ARID;
          rd_err   <= burst_err(s_axi_ARSIZE, s_axi_ARBURST, DataWidthBytesLog);
        end
        R_BURST: if (r_hs && ret_is_last) rd_state <= R_IDLE;
        default: rd_state <= R_IDLE;
      endcase
    end
  end

  // Issue side runs ahead of the return side; the two only meet at len.
  logic [8:0]           iss_beat_unused;
  logic                 iss_last_unused;
  logic [8:0]           ret_beat_unused;
  logic [AddrWidth-1:0] ret_addr_unused;
  logic                 ret_range_unused;

  mmap_beat_addr_gen #(
    .AddrWidth        (AddrWidth),
    .DataWidthBytesLog(DataWidthBytesLog)
  ) u_rd_issue (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (ar_hs),
    .base    (s_axi_ARADDR),
    .len     (s_axi_ARLEN),
    .step    (read_addr_write),
    .beat    (iss_beat_unused),
    .addr    (iss_addr),
    .is_last (iss_last_unused),
    .in_range(iss_in_range)
  );

  mmap_beat_addr_gen #(
    .AddrWidth        (AddrWidth),
    .DataWidthBytesLog(DataWidthBytesLog)
  ) u_rd_return (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (ar_hs),
    .base    (s_axi_ARADDR),
    .len     (s_axi_ARLEN),
    .step    (r_hs),
    .beat    (ret_beat_unused),
    .addr    (ret_addr_unused),
    .is_last (ret_is_last),
    .in_range(ret_range_unused)
  );

  // ---------------------------------------------------------------------------
  // Write path
  // ---------------------------------------------------------------------------
  wr_state_e            wr_state;
  logic                 wr_err;
  logic [IdWidth-1:0]   wr_id;
  logic                 aw_hs;
  logic                 w_hs;
  logic                 b_hs;
  logic [AddrWidth-1:0] wr_addr;
  logic                 wr_is_last;
  logic [8:0]           wr_beat_unused;
  logic                 wr_range_unused;

  assign s_axi_AWREADY    = init_done && (wr_state == W_IDLE);
  assign aw_hs            = s_axi_AWVALID && s_axi_AWREADY;

  // Both user FIFOs must have room so address and data stay paired.
  assign s_axi_WREADY     = (wr_state == W_DATA) && write_addr_full_n && write_data_full_n;
  assign w_hs             = s_axi_WVALID && s_axi_WREADY;
  assign write_addr_write = w_hs;
  assign write_data_write = w_hs;
  assign write_addr_din   = wr_addr;
  assign write_data_din   = s_axi_WDATA;

  assign s_axi_BVALID     = (wr_state == W_RESP);
  assign b_hs             = s_axi_BVALID && s_axi_BREADY;
  assign s_axi_BID        = wr_id;
  assign s_axi_BRESP      = wr_err ? AXI_RESP_SLVERR : AXI_RESP_OKAY;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_state <= W_IDLE;
      wr_err   <= 1'b0;
      wr_id    <= '0;
    end else begin
      case (wr_state)
        W_IDLE: if (aw_hs) begin
          wr_state <= W_DATA;
          wr_id    <= s_axi_AWID;
          wr_err   <= burst_err(s_axi_AWSIZE, s_axi_AWBURST, DataWidthBytesLog);
        end
        W_DATA: if (w_hs) begin
          // Partial strobes or a misplaced WLAST are reported, not dropped;
          // the beat count alone ends the burst.
          if ((s_axi_WSTRB != '1) || (s_axi_WLAST != wr_is_last)) wr_err <= 1'b1;
          if (wr_is_last) wr_state <= W_RESP;
        end
        W_RESP: if (b_hs) wr_state <= W_IDLE;
        default: wr_state <= W_IDLE;
      endcase
    end
  end

  mmap_beat_addr_gen #(
    .AddrWidth        (AddrWidth),
    .DataWidthBytesLog(DataWidthBytesLog)
  ) u_wr (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (aw_hs),
    .base    (s_axi_AWADDR),
    .len     (s_axi_AWLEN),
    .step    (w_hs),
    .beat    (wr_beat_unused),
    .addr    (wr_addr),
    .is_last (wr_is_last),
    .in_range(wr_range_unused)
  );

  // Generator outputs this instance arrangement does not need.
  logic unused_gen_bits;
  assign unused_gen_bits = ^{iss_beat_unused, iss_last_unused, ret_beat_unused,
                             ret_addr_unused, ret_range_unused, wr_beat_unused,
                             wr_range_unused};

endmodule

// File: tb/tb_mmap_axi_responder.sv
// -----------------------------------------------------------------------------
// tb_mmap_axi_responder
// Drives AXI bursts into mmap_axi_responder and plays the user-side memory.
// Expected beat addresses, data, flags and responses come from a burst-level
// model: beat i lives at base + i*64, read data is a fixed function of the
// address, and a burst errors on bad size/type/strobe/WLAST.
// -----------------------------------------------------------------------------
module tb_mmap_axi_responder;

  localparam int AW  = 64;
  localparam int DW  = 512;
  localparam int DBL = 6;
  localparam int IW  = 1;
  localparam int SW  = DW / 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          s_axi_ARVALID, s_axi_ARREADY;
  logic [AW-1:0] s_axi_ARADDR;
  logic [IW-1:0] s_axi_ARID;
  logic [7:0]    s_axi_ARLEN;
  logic [2:0]    s_axi_ARSIZE;
  logic [1:0]    s_axi_ARBURST;
  logic          s_axi_RVALID, s_axi_RREADY;
  logic [DW-1:0] s_axi_RDATA;
  logic [IW-1:0] s_axi_RID;
  logic [1:0]    s_axi_RRESP;
  logic          s_axi_RLAST;
  logic          s_axi_AWVALID, s_axi_AWREADY;
  logic [AW-1:0] s_axi_AWADDR;
  logic [IW-1:0] s_axi_AWID;
  logic [7:0]    s_axi_AWLEN;
  logic [2:0]    s_axi_AWSIZE;
  logic [1:0]    s_axi_AWBURST;
  logic          s_axi_WVALID, s_axi_WREADY;
  logic [DW-1:0] s_axi_WDATA;
  logic [SW-1:0] s_axi_WSTRB;
  logic          s_axi_WLAST;
  logic          s_axi_BVALID, s_axi_BREADY;
  logic [IW-1:0] s_axi_BID;
  logic [1:0]    s_axi_BRESP;
  logic [AW-1:0] read_addr_din;
  logic          read_addr_write, read_addr_full_n;
  logic [DW-1:0] read_data_dout;
  logic          read_data_empty_n, read_data_read;
  logic [AW-1:0] write_addr_din;
  logic          write_addr_write, write_addr_full_n;
  logic [DW-1:0] write_data_din;
  logic          write_data_write, write_data_full_n;

  mmap_axi_responder #(
    .AddrWidth(AW), .DataWidth(DW), .DataWidthBytesLog(DBL), .IdWidth(IW)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .s_axi_ARVALID(s_axi_ARVALID), .s_axi_ARREADY(s_axi_ARREADY),
    .s_axi_ARADDR(s_axi_ARADDR), .s_axi_ARID(s_axi_ARID), .s_axi_ARLEN(s_axi_ARLEN),
    .s_axi_ARSIZE(s_axi_ARSIZE), .s_axi_ARBURST(s_axi_ARBURST),
    .s_axi_RVALID(s_axi_RVALID), .s_axi_RREADY(s_axi_RREADY), .s_axi_RDATA(s_axi_RDATA),
    .s_axi_RID(s_axi_RID), .s_axi_RRESP(s_axi_RRESP), .s_axi_RLAST(s_axi_RLAST),
    .s_axi_AWVALID(s_axi_AWVALID), .s_axi_AWREADY(s_axi_AWREADY),
    .s_axi_AWADDR(s_axi_AWADDR), .s_axi_AWID(s_axi_AWID), .s_axi_AWLEN(s_axi_AWLEN),
    .s_axi_AWSIZE(s_axi_AWSIZE), .s_axi_AWBURST(s_axi_AWBURST),
    .s_axi_WVALID(s_axi_WVALID), .s_axi_WREADY(s_axi_WREADY), .s_axi_WDATA(s_axi_WDATA),
    .s_axi_WSTRB(s_axi_WSTRB), .s_axi_WLAST(s_axi_WLAST),
    .s_axi_BVALID(s_axi_BVALID), .s_axi_BREADY(s_axi_BREADY), .s_axi_BID(s_axi_BID),
    .s_axi_BRESP(s_axi_BRESP),
    .read_addr_din(read_addr_din), .read_addr_write(read_addr_write),
    .read_addr_full_n(read_addr_full_n),
    .read_data_dout(read_data_dout), .read_data_empty_n(read_data_empty_n),
    .read_data_read(read_data_read),
    .write_addr_din(write_addr_din), .write_addr_write(write_addr_write),
    .write_addr_full_n(write_addr_full_n),
    .write_data_din(write_data_din), .write_data_write(write_data_write),
    .write_data_full_n(write_data_full_n)
  );

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wbeat_t;

  int n_tests = 0;
  int n_fail  = 0;

  logic [AW-1:0] rq[$];     // read addresses issued, awaiting data
  wbeat_t        wq[$];     // write beats forwarded to the user
  int            wstall_req = 0;
  bit            wstall_now = 1'b0;

  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Memory contents as seen by the user model: a fixed function of address.
  function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] addr);
    logic [DW-1:0] w;
    for (int k = 0; k < DW / 64; k++)
      w[k*64 +: 64] = addr ^ (64'(k + 1) * 64'hD1B5_4A32_D192_ED03);
    return w;
  endfunction

  function automatic logic [DW-1:0] rand_data();
    logic [DW-1:0] r;
    for (int k = 0; k < DW / 32; k++) r[k*32 +: 32] = $urandom;
    return r;
  endfunction

  // User read side: accepts addresses, returns data in issue order.
  initial begin
    read_addr_full_n  = 1'b0;
    read_data_empty_n = 1'b0;
    read_data_dout    = '0;
    forever begin
      @(negedge clk);
      read_addr_full_n = ($urandom_range(0, 4) != 0);
      if (rq.size() > 0 && $urandom_range(0, 3) != 0) begin
        read_data_empty_n = 1'b1;
        read_data_dout    = mem_word(rq[0]);
      end else begin
        read_data_empty_n = 1'b0;
        read_data_dout    = '0;
      end
      #1;
      if (!rst_n) rq.delete();
      else begin
        if (read_data_read) void'(rq.pop_front());
        if (read_addr_write) rq.push_back(read_addr_din);
      end
    end
  end

  // User write side: collects address/data pairs, can be stalled on request.
  initial begin
    write_addr_full_n = 1'b0;
    write_data_full_n = 1'b0;
    forever begin
      @(negedge clk);
      if (wstall_req > 0) begin
        write_data_full_n = 1'b0;
        wstall_req--;
        wstall_now = 1'b1;
      end else begin
        write_data_full_n = ($urandom_range(0, 4) != 0);
        wstall_now = 1'b0;
      end
      write_addr_full_n = ($urandom_range(0, 4) != 0);
      #1;
      if (rst_n && (write_addr_write || write_data_write)) begin
        check("wr_pulse_pair", write_data_write, write_addr_write);
        wq.push_back('{addr: write_addr_din, data: write_data_din});
      end
    end
  end

  task automatic do_read(input logic [AW-1:0] base, input int len, input logic [2:0] size,
                         input logic [1:0] burst, input logic [IW-1:0] id, input int abort_after);
    int            beat;
    int            cyc;
    logic [1:0]    exp_resp;
    logic [AW-1:0] exp_addr;
    exp_resp = (size != 3'(DBL) || burst != 2'b01) ? 2'b10 : 2'b00;
    @(negedge clk);
    s_axi_ARVALID = 1'b1; s_axi_ARADDR = base; s_axi_ARLEN = 8'(len);
    s_axi_ARSIZE = size; s_axi_ARBURST = burst; s_axi_ARID = id;
    #1;
    cyc = 0;
    while (!s_axi_ARREADY && cyc < 200) begin @(negedge clk); #1; cyc++; end
    check("ar_handshake", s_axi_ARREADY, 1'b1);
    @(negedge clk);
    s_axi_ARVALID = 1'b0;
    beat = 0; cyc = 0;
    while (beat <= len && beat != abort_after && cyc < 5000) begin
      s_axi_RREADY = ($urandom_range(0, 3) != 0);
      #1;
      if (s_axi_RVALID && s_axi_RREADY) begin
        exp_addr = base + 64'(beat) * 64'(SW);
        check("rdata", s_axi_RDATA, mem_word(exp_addr));
        check("rlast", s_axi_RLAST, (beat == len));
        check("rid", s_axi_RID, id);
        check("rresp", s_axi_RRESP, exp_resp);
        beat++;
      end
      @(negedge clk);
      cyc++;
    end
    s_axi_RREADY = 1'b0;
    if (abort_after >= 0) begin
      check("r_abort_beats", beat, abort_after);
      return;
    end
    check("r_beats", beat, len + 1);
    repeat (2) @(negedge clk);
    #1;
    check("r_no_extra_issue", rq.size(), 0);
  endtask

  task automatic do_write(input logic [AW-1:0] base, input int len, input logic [IW-1:0] id,
                          input logic [2:0] size, input logic [1:0] burst, input int strb_bad_beat,
                          input bit wlast_early, input int stall_at, input int bready_delay);
    wbeat_t        exp_q[$];
    logic [DW-1:0] d;
    int            beat;
    int            cyc;
    logic          err;
    err = (size != 3'(DBL)) || (burst != 2'b01) ||
          (strb_bad_beat >= 0 && strb_bad_beat <= len) || (wlast_early && len > 0);
    wq.delete();
    @(negedge clk);
    s_axi_AWVALID = 1'b1; s_axi_AWADDR = base; s_axi_AWLEN = 8'(len);
    s_axi_AWSIZE = size; s_axi_AWBURST = burst; s_axi_AWID = id;
    #1;
    cyc = 0;
    while (!s_axi_AWREADY && cyc < 200) begin @(negedge clk); #1; cyc++; end
    check("aw_handshake", s_axi_AWREADY, 1'b1);
    @(negedge clk);
    s_axi_AWVALID = 1'b0;
    beat = 0; cyc = 0;
    d = rand_data();
    while (beat <= len && cyc < 5000) begin
      s_axi_WVALID = ($urandom_range(0, 3) != 0);
      s_axi_WDATA  = d;
      s_axi_WSTRB  = (beat == strb_bad_beat) ? {{(SW/2){1'b0}}, {(SW/2){1'b1}}} : '1;
      s_axi_WLAST  = wlast_early ? (beat == 0) : (beat == len);
      #1;
      if (wstall_now) check("wready_stall", s_axi_WREADY, 1'b0);
      if (s_axi_WVALID && s_axi_WREADY) begin
        exp_q.push_back('{addr: base + 64'(beat) * 64'(SW), data: d});
        if (beat == stall_at) wstall_req = 3;
        beat++;
        d = rand_data();
      end
      @(negedge clk);
      cyc++;
    end
    s_axi_WVALID = 1'b0;
    s_axi_WLAST  = 1'b0;
    check("w_beats", beat, len + 1);
    for (int c = 0; c <= bready_delay; c++) begin
      s_axi_BREADY = (c == bready_delay);
      #1;
      check("bvalid", s_axi_BVALID, 1'b1);
      if (c < bready_delay) check("awready_hold", s_axi_AWREADY, 1'b0);
      else begin
        check("bid", s_axi_BID, id);
        check("bresp", s_axi_BRESP, err ? 2'b10 : 2'b00);
      end
      @(negedge clk);
    end
    s_axi_BREADY = 1'b0;
    check("w_fwd_count", wq.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < wq.size(); i++) begin
      check("w_fwd_addr", wq[i].addr, exp_q[i].addr);
      check("w_fwd_data", wq[i].data, exp_q[i].data);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    s_axi_ARVALID = 0; s_axi_ARADDR = '0; s_axi_ARID = '0; s_axi_ARLEN = '0;
    s_axi_ARSIZE = '0; s_axi_ARBURST = '0; s_axi_RREADY = 0;
    s_axi_AWVALID = 0; s_axi_AWADDR = '0; s_axi_AWID = '0; s_axi_AWLEN = '0;
    s_axi_AWSIZE = '0; s_axi_AWBURST = '0;
    s_axi_WVALID = 0; s_axi_WDATA = '0; s_axi_WSTRB = '0; s_axi_WLAST = 0; s_axi_BREADY = 0;

    repeat (3) @(negedge clk);
    #1;
    check("rst_arready", s_axi_ARREADY, 1'b0);
    check("rst_awready", s_axi_AWREADY, 1'b0);
    check("rst_rvalid", s_axi_RVALID, 1'b0);
    check("rst_bvalid", s_axi_BVALID, 1'b0);
    check("rst_wready", s_axi_WREADY, 1'b0);
    check("rst_rd_addr_write", read_addr_write, 1'b0);
    check("rst_wr_addr_write", write_addr_write, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rel_arready_c1", s_axi_ARREADY, 1'b0);
    check("rel_awready_c1", s_axi_AWREADY, 1'b0);
    @(negedge clk);
    #1;
    check("rel_arready_c2", s_axi_ARREADY, 1'b1);
    check("rel_awready_c2", s_axi_AWREADY, 1'b1);

    // Directed bursts
    do_read(64'h1000, 3, 3'd6, 2'b01, 1'b1, -1);
    do_write(64'h2000, 1, 1'b0, 3'd6, 2'b01, -1, 1'b0, -1, 0);
    do_write(64'h3000, 5, 1'b1, 3'd6, 2'b01, -1, 1'b0, 1, 5);
    do_write(64'h4000, 2, 1'b0, 3'd6, 2'b01, 0, 1'b0, -1, 0);
    do_read(64'h5000, 2, 3'd6, 2'b00, 1'b0, -1);
    do_read(64'hFFFF_FFFF_FFFF_FFC0, 1, 3'd6, 2'b01, 1'b1, -1);
    do_read(64'h8000, 255, 3'd6, 2'b01, 1'b0, -1);
    do_write(64'h6000, 2, 1'b1, 3'd6, 2'b01, -1, 1'b1, -1, 1);
    do_write(64'h7000, 0, 1'b1, 3'd5, 2'b01, -1, 1'b0, -1, 0);

    // Address channels handshaking in the same cycle
    fork
      do_read(64'hA000, 2, 3'd6, 2'b01, 1'b1, -1);
      do_write(64'hB000, 2, 1'b0, 3'd6, 2'b01, -1, 1'b0, -1, 2);
    join

    // Reset in the middle of a read burst
    do_read(64'hC000, 3, 3'd6, 2'b01, 1'b1, 2);
    rst_n = 1'b0;
    #1;
    check("midrst_rvalid", s_axi_RVALID, 1'b0);
    check("midrst_rd_addr_write", read_addr_write, 1'b0);
    check("midrst_rd_data_read", read_data_read, 1'b0);
    check("midrst_arready", s_axi_ARREADY, 1'b0);
    check("midrst_bvalid", s_axi_BVALID, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("midrst_rel_arready_c1", s_axi_ARREADY, 1'b0);
    @(negedge clk);
    #1;
    check("midrst_rel_arready_c2", s_axi_ARREADY, 1'b1);
    do_read(64'hD000, 0, 3'd6, 2'b01, 1'b0, -1);

    // Randomized concurrent bursts
    for (int it = 0; it < 20; it++) begin
      logic [AW-1:0] ra, wa;
      int            rl, wl, sb;
      logic [2:0]    rs, ws;
      logic [1:0]    rb, wb;
      ra = {$urandom, $urandom};
      wa = {$urandom, $urandom};
      rl = $urandom_range(0, 15);
      wl = $urandom_range(0, 15);
      rs = ($urandom_range(0, 5) == 0) ? 3'd5 : 3'd6;
      ws = ($urandom_range(0, 5) == 0) ? 3'd4 : 3'd6;
      rb = ($urandom_range(0, 5) == 0) ? 2'b10 : 2'b01;
      wb = ($urandom_range(0, 5) == 0) ? 2'b00 : 2'b01;
      sb = ($urandom_range(0, 3) == 0) ? $urandom_range(0, wl) : -1;
      fork
        do_read(ra, rl, rs, rb, 1'($urandom), -1);
        do_write(wa, wl, 1'($urandom), ws, wb, sb, 1'b0, -1, $urandom_range(0, 3));
      join
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
